e20_program_loader: RTL and testbench

Byte-stream program loader for the E20 processor. Accepts a length-prefixed stream of program words over a valid/ready byte interface and writes them into the processor's instruction/data RAM through a single write port. Holds the processor in reset while loading, releases it when the load completes, then watches halt and counts run cycles. Sits between a host link (UART/JTAG bridge) and the processor's RAM write port and reset.

---
 rtl/e20_pkg.sv | 26 ++
 rtl/e20_byte_pair_assembler.sv | 29 ++
 rtl/e20_program_loader.sv | 154 +++++++++++++++
 tb/tb_e20_program_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e20_pkg.sv
// Shared types and constants for the E20 program loader.
// The loader walks a length-prefixed byte stream, then supervises one processor run.
package e20_pkg;

    localparam int E20_WORD_W    = 16;
    localparam int E20_ADDR_W    = 13;
    localparam int E20_RAM_DEPTH = 8192;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    // The four stream-consuming states: the host may push bytes and the loader counts as busy.
    function automatic logic is_loading(input loader_state_t s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) ||
               (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/e20_byte_pair_assembler.sv
// Joins two MSB-first bytes into one 16-bit word.
// The caller says which half is arriving, so header and data words share this path.
module e20_byte_pair_assembler
    import e20_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  take,
    input  logic                  low_half,
    input  logic [7:0]            data,
    output logic                  word_valid,
    output logic [E20_WORD_W-1:0] word
);

    logic [7:0] hi_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_byte <= 8'h00;
        end else if (take && !low_half) begin
            hi_byte <= data;
        end
    end

    // The low byte completes the word in the same cycle it is transferred.
    assign word_valid = take && low_half;
    assign word       = {hi_byte, data};

endmodule

// File: rtl/e20_program_loader.sv
// Loads a length-prefixed program into E20 RAM, holds the CPU in reset while loading,
// then releases it and counts run cycles until halt.
module e20_program_loader
    import e20_pkg::*;
#(
    parameter int ADDR_W = E20_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [E20_WORD_W-1:0] mem_wdata,
    output logic                  cpu_reset,
    input  logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      run_cycles
);

    localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

    loader_state_t         state;
    logic [15:0]           word_count;
    logic [ADDR_W-1:0]     word_idx;
    logic                  take;
    logic                  low_half;
    logic                  word_valid;
    logic [E20_WORD_W-1:0] word;
    logic                  count_zero;
    logic                  count_too_big;
    logic                  last_word;

    assign s_ready  = is_loading(state);
    assign take     = s_valid && s_ready;
    assign low_half = (state == ST_HDR_LO) || (state == ST_DATA_LO);

    e20_byte_pair_assembler u_assembler (
        .clock      (clock),
        .reset      (reset),
        .take       (take),
        .low_half   (low_half),
        .data       (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Header checks use the freshly assembled word; the 32-bit compare keeps 2**ADDR_W exact.
    assign count_zero    = (word == 16'd0);
    assign count_too_big = {16'd0, word} > DEPTH;
    assign last_word     = (32'(word_idx) + 32'd1) == {16'd0, word_count};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_HDR_HI;
            word_count <= 16'd0;
            word_idx   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            run_cycles <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_HDR_HI: begin
                    if (take) begin
                        state <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (word_valid) begin
                        word_count <= word;
                        if (count_zero) begin
                            state <= ST_START;
                            busy  <= 1'b0;
                        end else if (count_too_big) begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (take) begin
                        state <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (word_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= word;
                        word_idx  <= word_idx + 1'b1;
                        if (last_word) begin
                            state <= ST_START;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA_HI;
                        end
                    end
                end
                ST_START: begin
                    state     <= ST_RUN;
                    cpu_reset <= 1'b0;
                end
                ST_RUN: begin
                    // The halting cycle is still a run cycle, so count before leaving.
                    if (!(&run_cycles)) begin
                        run_cycles <= run_cycles + CNT_W'(1);
                    end
                    if (cpu_halt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        state      <= ST_HDR_HI;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        run_cycles <= '0;
                        word_idx   <= '0;
                    end
                end
                ST_ERR: begin
                    if (restart) begin
                        state      <= ST_HDR_HI;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        cpu_reset  <= 1'b1;
                        run_cycles <= '0;
                        word_idx   <= '0;
                    end
                end
                default: begin
                    state <= ST_HDR_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e20_program_loader.sv
// Randomized bench for e20_program_loader: byte streams are turned into expected RAM
// writes by a stream-level model and compared with what the loader actually wrote.
module tb_e20_program_loader;

    localparam int ADDR_W = 13;
    localparam int CNT_W  = 32;
    localparam int DEPTH  = 8192;

    logic              clock = 1'b0;
    logic              reset;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              restart;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_reset;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  run_cycles;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [28:0] exp_q[$];
    logic [28:0] wr_q[$];
    bit          exp_err;

    e20_program_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .restart    (restart),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .run_cycles (run_cycles)
    );

    always #5 clock = ~clock;

    // Every RAM write strobe seen mid-cycle is logged as {addr, data}.
    always @(negedge clock) begin
        if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream-level model: count from the first two bytes, then word i lands at address i.
    task automatic buildModel();
        int n;
        exp_q.delete();
        n = int'({stream[0], stream[1]});
        exp_err = (n > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({13'(i), stream[2 + 2 * i], stream[3 + 2 * i]});
        end
    endtask

    task automatic setStream(input int n, input bit rnd, input logic [15:0] fixed[]);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = rnd ? 16'($urandom) : fixed[i];
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        @(negedge clock);
        while (s_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            s_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int max_gap);
        buildModel();
        wr_q.delete();
        foreach (stream[i]) sendByte(stream[i], max_gap);
        s_valid = 1'b0;
    endtask

    task automatic compareWrites(input string tag);
        int bad;
        int n;
        bad = 0;
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        checkOutput({tag, "_wr_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < n; i++)
            if (wr_q[i] !== exp_q[i]) bad++;
        checkOutput({tag, "_wr_bad"}, 32'(bad), 32'd0);
    endtask

    // Called right after the final byte's transfer edge: START cycle, then first RUN cycle.
    task automatic checkStartRun(input string tag, input logic expect_we);
        @(negedge clock);
        checkOutput({tag, "_start_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_start_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_start_we"}, 32'(mem_we), 32'(expect_we));
        @(negedge clock);
        checkOutput({tag, "_run_cpu_reset"}, 32'(cpu_reset), 32'd0);
        checkOutput({tag, "_run_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_run_we"}, 32'(mem_we), 32'd0);
        compareWrites(tag);
    endtask

    // Starts mid RUN cycle 1 and raises cpu_halt during RUN cycle k.
    task automatic haltAfter(input string tag, input int k, input bit poke_restart);
        for (int i = 1; i < k; i++) begin
            restart = poke_restart && (i == 1);
            @(posedge clock);
            #1;
        end
        restart  = 1'b0;
        cpu_halt = 1'b1;
        @(posedge clock);
        #1;
        cpu_halt = 1'b0;
        @(negedge clock);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_cycles"}, run_cycles, 32'(k));
        checkOutput({tag, "_done_cpu_reset"}, 32'(cpu_reset), 32'd0);
        checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
        repeat (20) @(negedge clock);
        checkOutput({tag, "_cycles_held"}, run_cycles, 32'(k));
        checkOutput({tag, "_done_held"}, 32'(done), 32'd1);
    endtask

    task automatic doRestart(input string tag);
        @(posedge clock);
        #1;
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
        checkOutput({tag, "_rs_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_rs_cycles"}, run_cycles, 32'd0);
        checkOutput({tag, "_rs_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_rs_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rs_error"}, 32'(error), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_run_cycles"}, run_cycles, 32'd0);
    endtask

    initial begin
        logic [15:0] prog[];
        logic [15:0] none[];
        prog = '{16'h2085, 16'h2103, 16'h09C0, 16'h0519, 16'h00EA, 16'h4005};
        none = new[0];

        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        restart  = 1'b0;
        cpu_halt = 1'b0;
        #12;
        checkResetValues("por");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        $display("[TB] normal load");
        setStream(6, 1'b0, prog);
        applyStimulus(0);
        checkStartRun("normal", 1'b1);
        haltAfter("normal", 40, 1'b1);

        $display("[TB] restart with single word");
        doRestart("restart");
        setStream(1, 1'b0, '{16'h1234});
        applyStimulus(0);
        checkStartRun("single", 1'b1);
        haltAfter("single", int'($urandom_range(30, 1)), 1'b0);

        $display("[TB] gapped stream");
        doRestart("gap");
        setStream(6, 1'b0, prog);
        applyStimulus(3);
        checkStartRun("gapped", 1'b1);
        haltAfter("gapped", int'($urandom_range(30, 1)), 1'b1);

        $display("[TB] zero-length program");
        doRestart("zero");
        setStream(0, 1'b0, none);
        applyStimulus(0);
        checkStartRun("zero", 1'b0);
        haltAfter("zero", int'($urandom_range(20, 1)), 1'b0);

        $display("[TB] random programs");
        for (int t = 0; t < 4; t++) begin
            doRestart("rnd");
            setStream(int'($urandom_range(24, 1)), 1'b1, none);
            applyStimulus(2);
            checkStartRun("rnd", 1'b1);
            haltAfter("rnd", int'($urandom_range(25, 1)), 1'b1);
        end

        $display("[TB] full-depth program");
        doRestart("full");
        setStream(DEPTH, 1'b1, none);
        applyStimulus(0);
        checkStartRun("full", 1'b1);
        checkOutput("full_last_addr",
                    (wr_q.size() > 0) ? 32'(wr_q[wr_q.size() - 1][28:16]) : 32'hFFFF_FFFF,
                    32'(DEPTH - 1));
        haltAfter("full", int'($urandom_range(10, 1)), 1'b0);

        $display("[TB] oversize count");
        doRestart("over");
        stream.delete();
        stream.push_back(8'h20);
        stream.push_back(8'h01);
        applyStimulus(0);
        checkOutput("over_model_err", 32'(exp_err), 32'd1);
        @(negedge clock);
        checkOutput("over_error", 32'(error), 32'd1);
        checkOutput("over_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("over_s_ready", 32'(s_ready), 32'd0);
        checkOutput("over_busy", 32'(busy), 32'd0);
        checkOutput("over_done", 32'(done), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (3) @(negedge clock);
        s_valid = 1'b0;
        checkOutput("over_still_err", 32'(error), 32'd1);
        compareWrites("over");
        doRestart("from_err");

        $display("[TB] reset mid-load");
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h04);
        stream.push_back(8'hAA);
        stream.push_back(8'hBB);
        stream.push_back(8'hCC);
        applyStimulus(0);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("midload");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        setStream(2, 1'b0, '{16'hABCD, 16'hEF01});
        applyStimulus(1);
        checkStartRun("fresh", 1'b1);
        haltAfter("fresh", int'($urandom_range(15, 1)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
